icache_axi_refill: RTL and testbench

ICACHE_AXI_REFILL -- requirements
Module: icache_axi_refill

---
 rtl/icache_axi_refill_pkg.sv | 18 +
 rtl/icache_axi_refill.sv | 123 ++++++++++++
 tb/tb_icache_axi_refill.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_axi_refill_pkg.sv
// Shared bus types and AXI encodings for the instruction-cache refill path.
package pipeline_types;

   localparam int ICACHE_LINE_WORDS = 8;
   localparam int ICACHE_LINE_BYTES = ICACHE_LINE_WORDS * 4;

   typedef logic [31:0]                      bus32_t;
   typedef logic [32*ICACHE_LINE_WORDS-1:0]  bus256_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

   // Aligns a byte address down to the start of its cache line.
   function automatic bus32_t line_base(input bus32_t addr);
      return addr & ~bus32_t'(ICACHE_LINE_BYTES - 1);
   endfunction

endpackage

// File: rtl/icache_axi_refill.sv
// Turns an icache line-refill request into one AXI INCR read burst and
// returns the assembled line for a single cycle.
module icache_axi_refill
   import pipeline_types::*;
#(
   parameter logic [3:0] AXI_ID     = 4'd0,
   parameter int         LINE_WORDS = ICACHE_LINE_WORDS
) (
   input  logic        aclk,
   input  logic        aresetn,
   // icache_mem slave side
   input  logic        rd_req,
   input  bus32_t      rd_addr,
   output logic        ret_valid,
   output bus256_t     ret_data,
   // AXI read-address channel
   output logic [3:0]  arid,
   output bus32_t      araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   // AXI read-data channel
   input  logic [3:0]  rid,
   input  bus32_t      rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   typedef enum logic [1:0] {
      IDLE,
      AR,
      R,
      RET
   } state_e;

   localparam logic [2:0] LAST_CNT = 3'(LINE_WORDS - 1);

   state_e      state_q;
   bus32_t      addr_q;
   logic [2:0]  cnt_q;
   logic        arvalid_q;
   logic        rready_q;
   logic        ret_valid_q;
   bus32_t      line_q [ICACHE_LINE_WORDS];

   // The port is dedicated to this block, so response status and ID carry no information.
   logic unused_rsp;
   assign unused_rsp = ^{rid, rresp};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         ret_valid_q <= 1'b0;
         // NOTE: the line buffer is reset because ret_data is visible in every state and must read 0 after reset.
         for (int w = 0; w < ICACHE_LINE_WORDS; w++) begin
            line_q[w] <= '0;
         end
      end else begin
         // NOTE: all state here uses <= so every register samples pre-edge values, independent of statement order.
         unique case (state_q)
            IDLE: begin
               if (rd_req) begin
                  addr_q    <= line_base(rd_addr);
                  cnt_q     <= '0;
                  arvalid_q <= 1'b1;
                  state_q   <= AR;
                  for (int w = 0; w < ICACHE_LINE_WORDS; w++) begin
                     line_q[w] <= '0;
                  end
               end
            end
            AR: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= R;
               end
            end
            R: begin
               if (rvalid) begin
                  line_q[cnt_q] <= rdata;
                  cnt_q         <= cnt_q + 3'd1;
                  // A short burst ends on rlast; a slave that never raises rlast is cut off after a full line.
                  if (rlast || cnt_q == LAST_CNT) begin
                     rready_q    <= 1'b0;
                     ret_valid_q <= 1'b1;
                     state_q     <= RET;
                  end
               end
            end
            RET: begin
               ret_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign arid      = AXI_ID;
   assign araddr    = addr_q;
   assign arlen     = 8'(LINE_WORDS - 1);
   assign arsize    = AXI_SIZE_4B;
   assign arburst   = AXI_BURST_INCR;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;
   assign ret_valid = ret_valid_q;

   for (genvar w = 0; w < ICACHE_LINE_WORDS; w++) begin : g_pack
      assign ret_data[32*w +: 32] = line_q[w];
   end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed bench: stimulus pushes expected AR/line results into queues,
// a negedge monitor pops and compares them whenever the DUT presents them.
module tb_icache_axi_refill;
   import pipeline_types::*;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b1;
   logic        rd_req = 1'b0;
   bus32_t      rd_addr = '0;
   logic        ret_valid;
   bus256_t     ret_data;
   logic [3:0]  arid;
   bus32_t      araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [3:0]  rid = 4'hF;
   bus32_t      rdata = '0;
   logic [1:0]  rresp = 2'b10;
   logic        rlast = 1'b0;
   logic        rvalid = 1'b0;
   logic        rready;

   icache_axi_refill #(.AXI_ID(4'd0), .LINE_WORDS(8)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .rd_req(rd_req), .rd_addr(rd_addr), .ret_valid(ret_valid), .ret_data(ret_data),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc++;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bus256_t data;
      int      req_cyc;
      int      lat;
   } ret_exp_t;

   bus32_t   exp_ar_q [$];
   ret_exp_t exp_ret_q [$];
   bus32_t   vec [8];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: compares AR handshakes and returned lines against the queues.
   always @(negedge aclk) begin
      if (aresetn) begin
         if (arvalid && arready) begin
            if (exp_ar_q.size() == 0) begin
               check("ar_unexpected", 1, 0);
            end else begin
               bus32_t a;
               a = exp_ar_q.pop_front();
               check("araddr", araddr, a);
               check("arlen", arlen, 8'd7);
               check("arsize_burst_id", {arsize, arburst, arid}, {3'b010, 2'b01, 4'd0});
            end
         end
         if (ret_valid) begin
            if (exp_ret_q.size() == 0) begin
               check("ret_unexpected", 1, 0);
            end else begin
               ret_exp_t e;
               e = exp_ret_q.pop_front();
               check("ret_data", ret_data, e.data);
               if (e.lat >= 0) check("ret_latency", cyc - e.req_cyc, e.lat);
            end
         end
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic bus256_t build_line(input int n);
      bus256_t l;
      l = '0;
      for (int i = 0; i < n; i++) l[32*i +: 32] = vec[i];
      return l;
   endfunction

   // Issues a request on the next edge and records what the DUT must produce.
   task automatic start_req(input bus32_t addr, input int n_words, input int lat, input bit push_ret);
      ret_exp_t e;
      e.data    = build_line(n_words);
      e.req_cyc = cyc;
      e.lat     = lat;
      exp_ar_q.push_back(addr & 32'hFFFF_FFE0);
      if (push_ret) exp_ret_q.push_back(e);
      rd_req  = 1'b1;
      rd_addr = addr;
      tick();
      rd_req  = 1'b0;
   endtask

   task automatic ar_phase(input int stall);
      int n;
      bus32_t held;
      n = 0;
      while (!arvalid && n < 20) begin
         tick();
         n++;
      end
      check("arvalid_seen", arvalid, 1'b1);
      held = araddr;
      for (int i = 0; i < stall; i++) begin
         arready = 1'b0;
         tick();
         check("ar_stall_hold", {arvalid, araddr, arlen, arsize, arburst}, {1'b1, held, 8'd7, 3'b010, 2'b01});
      end
      arready = 1'b1;
      tick();
      arready = 1'b0;
   endtask

   // Drives n beats; rlast on beat last_beat (1-based, 0 = never); 2-cycle gap after beats in gap_mask.
   task automatic r_phase(input int n, input int last_beat, input logic [7:0] gap_mask);
      for (int i = 0; i < n; i++) begin
         int w;
         w = 0;
         while (!rready && w < 20) begin
            tick();
            w++;
         end
         if (!rready) check("rready_seen", rready, 1'b1);
         rvalid = 1'b1;
         rdata  = vec[i];
         rlast  = (i + 1 == last_beat);
         tick();
         rvalid = 1'b0;
         rlast  = 1'b1;
         rdata  = 32'hDEAD_BEEF;
         if (gap_mask[i]) repeat (2) tick();
      end
      rlast = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_ret_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      check("ret_drained", exp_ret_q.size(), 0);
      tick();
   endtask

   initial begin
      #1 aresetn = 1'b0;
      #2;
      check("reset_outputs", {arvalid, rready, ret_valid, araddr}, 35'd0);
      check("reset_ret_data", ret_data, 256'd0);
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;

      // Basic refill, accepted on the first edge after reset release.
      for (int i = 0; i < 8; i++) vec[i] = 32'h1111_1111 * (i + 1);
      start_req(32'h1C00_0014, 8, 10, 1'b1);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      rd_addr = 32'hFFFF_FFFF;
      r_phase(8, 8, 8'h00);
      check("ret_word0", ret_data[31:0], 32'h1111_1111);
      check("ret_word7", ret_data[255:224], 32'h8888_8888);
      drain();
      check("araddr_ignores_rd_addr", araddr, 32'h1C00_0000);

      // Address and data stalls.
      for (int i = 0; i < 8; i++) vec[i] = 32'hA5A5_0000 + 32'(i * 3);
      start_req(32'h0000_2468, 8, 17, 1'b1);
      ar_phase(3);
      r_phase(8, 8, 8'b0001_0010);
      drain();

      // Early rlast on beat 4; remaining words must come back as zero.
      for (int i = 0; i < 8; i++) vec[i] = 32'hA + 32'(i);
      start_req(32'h0000_1000, 4, 6, 1'b1);
      ar_phase(0);
      r_phase(4, 4, 8'h00);
      check("early_upper_zero", ret_data[255:128], 128'd0);
      drain();

      // Missing rlast: cut off after 8 beats; rd_req held through RET restarts from IDLE.
      for (int i = 0; i < 8; i++) vec[i] = 32'hC0DE_0000 + 32'(i);
      start_req(32'h0800_0040, 8, 10, 1'b1);
      ar_phase(0);
      r_phase(8, 0, 8'h00);
      check("ret_after_beat8", {ret_valid, rready}, 2'b10);
      rvalid  = 1'b1;
      rd_req  = 1'b1;
      rd_addr = 32'h2000_0104;
      tick();
      rvalid  = 1'b0;
      check("idle_after_ret", {arvalid, rready, ret_valid}, 3'b000);
      for (int i = 0; i < 8; i++) vec[i] = 32'h5A00_0000 + 32'(i);
      start_req(32'h2000_0104, 8, 10, 1'b1);
      check("second_burst_ar", arvalid, 1'b1);
      ar_phase(0);
      r_phase(8, 8, 8'h00);
      drain();

      // Asynchronous reset in the middle of the R phase.
      for (int i = 0; i < 8; i++) vec[i] = 32'h7700_0000 + 32'(i);
      start_req(32'h3000_0008, 8, -1, 1'b0);
      ar_phase(0);
      r_phase(3, 0, 8'h00);
      #3 aresetn = 1'b0;
      arready = 1'b0;
      rvalid  = 1'b0;
      #1;
      check("midr_reset_ctrl", {arvalid, rready, ret_valid}, 3'b000);
      check("midr_reset_data", {ret_data, araddr}, 288'd0);
      @(negedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk);
      #1;
      for (int i = 0; i < 8; i++) vec[i] = 32'h0BAD_F00D ^ 32'(i << 4);
      start_req(32'h0000_0040, 8, 10, 1'b1);
      ar_phase(0);
      r_phase(8, 8, 8'h00);
      drain();

      check("ar_queue_empty", exp_ar_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
